// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_FILL  = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] ENTRY_COUNT = 8'h00;
  localparam logic [LED_W-1:0] ENTRY_SCAN  = 8'h01;
  localparam logic [LED_W-1:0] ENTRY_BLINK = 8'h00;
  localparam logic [LED_W-1:0] ENTRY_FILL  = 8'h00;

  function automatic mode_e next_mode(mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

  function automatic logic [LED_W-1:0] entry_led(mode_e m);
    case (m)
      MODE_COUNT: return ENTRY_COUNT;
      MODE_SCAN:  return ENTRY_SCAN;
      MODE_BLINK: return ENTRY_BLINK;
      default:    return ENTRY_FILL;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_key_debounce.sv
// One push-button: 2-flop synchroniser, stable counter, press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic s1;
  logic s2;
  logic level;
  logic prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_raw;
      s2    <= s1;
      prev  <= level;
      press <= prev & ~level;
      // any sample matching the level restarts the stability window
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Board LED bank driver: debounced keys select pattern and pause animation.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV        = 6250000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] KEY,
  output logic [7:0] LED,
  output logic [1:0] MODE,
  output logic       RUN
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [1:0]       press;
  logic [PW-1:0]    pre;
  logic             tick;
  logic             scan_up;
  mode_e            mode_q;
  logic [LED_W-1:0] led_nxt;
  logic             up_nxt;

  for (genvar g = 0; g < 2; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .key_raw(KEY[g]),
      .press  (press[g])
    );
  end

  assign tick = RUN && (pre == PRE_LAST);
  assign MODE = mode_q;

  always_comb begin
    led_nxt = LED;
    up_nxt  = scan_up;
    case (mode_q)
      MODE_COUNT: led_nxt = LED + 8'd1;
      MODE_SCAN: begin
        if (scan_up) begin
          if (LED == 8'h80) begin
            led_nxt = 8'h40;
            up_nxt  = 1'b0;
          end else begin
            led_nxt = LED << 1;
          end
        end else begin
          if (LED == 8'h01) begin
            led_nxt = 8'h02;
            up_nxt  = 1'b1;
          end else begin
            led_nxt = LED >> 1;
          end
        end
      end
      MODE_BLINK: led_nxt = ~LED;
      default:
        led_nxt = (LED == 8'hFF) ? 8'h00 : {LED[6:0], 1'b1};
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      LED     <= 8'h00;
      mode_q  <= MODE_COUNT;
      RUN     <= 1'b1;
      pre     <= '0;
      scan_up <= 1'b1;
    end else begin
      if (press[1]) RUN <= ~RUN;
      // a mode change swallows any tick in the same cycle
      if (press[0]) begin
        mode_q  <= next_mode(mode_q);
        LED     <= entry_led(next_mode(mode_q));
        pre     <= '0;
        scan_up <= 1'b1;
      end else if (RUN) begin
        if (tick) begin
          pre     <= '0;
          LED     <= led_nxt;
          scan_up <= up_nxt;
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed plus random stimulus against a pattern-index reference model.
module tb_led_pattern_sequencer;

  localparam int TD   = 4;
  localparam int DB   = 3;
  localparam int MAXC = 20000;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [1:0] KEY      = 2'b11;
  logic [7:0] LED;
  logic [1:0] MODE;
  logic       RUN;

  always #5 CLOCK_50 = ~CLOCK_50;

  led_pattern_sequencer #(
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .KEY     (KEY),
    .LED     (LED),
    .MODE    (MODE),
    .RUN     (RUN)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int m_mode;
  int m_idx;
  int m_run;
  int m_phase;
  int kc[2];
  bit kl[2];
  bit ev0[MAXC];
  bit ev1[MAXC];

  logic [7:0] saved;
  logic [7:0] scan_tab[16] = '{
    8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04
  };

  function automatic int period(int m);
    case (m)
      0: return 256;
      1: return 14;
      2: return 2;
      default: return 9;
    endcase
  endfunction

  function automatic logic [7:0] led_of(int m, int i);
    case (m)
      0: return 8'(i);
      1: return 8'(1 << ((i < 8) ? i : 14 - i));
      2: return (i != 0) ? 8'hFF : 8'h00;
      default: return 8'((1 << i) - 1);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(logic [1:0] k, logic r);
    bit p0;
    bit p1;
    bit tk;
    int run_b;
    if (!r) begin
      m_mode  = 0;
      m_idx   = 0;
      m_run   = 1;
      m_phase = 0;
      for (int i = 0; i < 2; i++) begin
        kc[i] = 0;
        kl[i] = 1'b1;
      end
      for (int t = cyc; t <= cyc + 8 && t < MAXC; t++) begin
        ev0[t] = 1'b0;
        ev1[t] = 1'b0;
      end
    end else begin
      p0    = ev0[cyc];
      p1    = ev1[cyc];
      run_b = m_run;
      tk    = (m_run != 0) && (m_phase == TD - 1);
      // accepted press reaches the FSM 4 edges after the last stable raw sample
      for (int i = 0; i < 2; i++) begin
        if (k[i] != kl[i]) begin
          kc[i]++;
          if (kc[i] == DB) begin
            kl[i] = k[i];
            kc[i] = 0;
            if (!k[i]) begin
              if (i == 0) ev0[cyc + 4] = 1'b1;
              else ev1[cyc + 4] = 1'b1;
            end
          end
        end else begin
          kc[i] = 0;
        end
      end
      if (p1) m_run = (m_run != 0) ? 0 : 1;
      if (p0) begin
        m_mode  = (m_mode + 1) % 4;
        m_idx   = 0;
        m_phase = 0;
      end else if (run_b != 0) begin
        m_phase = tk ? 0 : m_phase + 1;
        if (tk) m_idx = (m_idx + 1) % period(m_mode);
      end
    end
  endtask

  task automatic step(logic [1:0] k, logic r);
    KEY     = k;
    RESET_N = r;
    @(posedge CLOCK_50);
    cyc++;
    model_edge(k, r);
    #1;
    chk("led", LED, led_of(m_mode, m_idx));
    chk("mode", MODE, m_mode);
    chk("run", RUN, m_run);
  endtask

  task automatic press_pat(logic [1:0] pat);
    repeat (DB) step(pat, 1'b1);
    repeat (4) step(2'b11, 1'b1);
  endtask

  initial begin
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    chk("rst_led", LED, 8'h00);
    chk("rst_mode", MODE, 0);
    chk("rst_run", RUN, 1);

    for (int i = 1; i <= 12; i++) begin
      step(2'b11, 1'b1);
      if (i % 4 == 0) chk("count_step", LED, i / 4);
    end

    step(2'b10, 1'b1);
    step(2'b10, 1'b1);
    repeat (10) step(2'b11, 1'b1);
    chk("glitch_mode", MODE, 0);

    repeat (6) step(2'b10, 1'b1);
    chk("lat_early", MODE, 0);
    step(2'b11, 1'b1);
    chk("lat_mode", MODE, 1);
    chk("lat_led", LED, 8'h01);

    for (int t = 0; t < 16; t++) begin
      repeat (4) step(2'b11, 1'b1);
      chk("scan", LED, scan_tab[t]);
    end
    chk("release", MODE, 1);

    press_pat(2'b10);
    chk("blink_mode", MODE, 2);
    chk("blink_entry", LED, 8'h00);
    repeat (4) step(2'b11, 1'b1);
    chk("blink_on", LED, 8'hFF);
    repeat (4) step(2'b11, 1'b1);
    chk("blink_off", LED, 8'h00);

    press_pat(2'b10);
    chk("fill_mode", MODE, 3);
    for (int k = 1; k <= 9; k++) begin
      repeat (4) step(2'b11, 1'b1);
      chk("fill", LED, (k == 9) ? 0 : (1 << k) - 1);
    end
    press_pat(2'b10);
    chk("wrap_mode", MODE, 0);
    chk("wrap_led", LED, 8'h00);

    repeat (2) step(2'b11, 1'b1);
    press_pat(2'b01);
    chk("pause_run", RUN, 0);
    saved = led_of(m_mode, m_idx);
    repeat (100) begin
      step(2'b11, 1'b1);
      chk("frozen", LED, saved);
    end
    press_pat(2'b01);
    chk("resume_run", RUN, 1);

    for (int n = 0; n < TD && (m_phase + 6) % TD != TD - 1; n++)
      step(2'b11, 1'b1);
    press_pat(2'b10);
    chk("coll_mode", MODE, 1);
    chk("coll_led", LED, 8'h01);
    repeat (3) step(2'b11, 1'b1);
    chk("coll_noextra", LED, 8'h01);
    step(2'b11, 1'b1);
    chk("coll_next", LED, 8'h02);

    press_pat(2'b00);
    chk("both_mode", MODE, 2);
    chk("both_run", RUN, 0);
    press_pat(2'b01);

    step(2'b10, 1'b1);
    step(2'b10, 1'b1);
    step(2'b10, 1'b0);
    chk("mid_rst_mode", MODE, 0);
    step(2'b10, 1'b1);
    step(2'b10, 1'b1);
    repeat (20) step(2'b11, 1'b1);
    chk("mid_rst_noev", MODE, 0);

    for (int n = 0; n < 400; n++) begin
      logic [1:0] pat;
      int len;
      logic r;
      pat = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 6));
      r   = ($urandom_range(0, 60) != 0);
      step(pat, r);
      repeat (len - 1) step(pat, 1'b1);
    end
    repeat (30) step(2'b11, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
